// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB stage.
// Holds the FSM encoding and the MEM/WB register layout.
package mem_wb_stage_pkg;

    localparam int WORD_W        = 32;
    localparam int REG_IDX_W     = 4;
    localparam int DEF_ADDR_BASE = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic                 wb_en;
        logic [REG_IDX_W-1:0] dest;
        logic                 load;
        logic [WORD_W-1:0]    alu;
        logic [WORD_W-1:0]    rdata;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs and writeback outputs of the MEM/WB stage.
// MEM_ALIGN_CHECK_EN adds the sticky misalign flag.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic                 MEM_R_EN;
    logic                 MEM_W_EN;
    logic                 WB_EN_in;
    logic [REG_IDX_W-1:0] Dest_in;
    logic [WORD_W-1:0]    ALU_Res;
    logic [WORD_W-1:0]    Val_Rm;
    logic                 freeze;
    logic                 WB_EN;
    logic [REG_IDX_W-1:0] WB_Dest;
    logic [WORD_W-1:0]    WB_Res;
`ifdef MEM_ALIGN_CHECK_EN
    logic                 misalign;

    modport master (
        output MEM_R_EN, MEM_W_EN, WB_EN_in,
        output Dest_in, ALU_Res, Val_Rm,
        input  freeze, WB_EN, WB_Dest, WB_Res,
        input  misalign
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, WB_EN_in,
        input  Dest_in, ALU_Res, Val_Rm,
        output freeze, WB_EN, WB_Dest, WB_Res,
        output misalign
    );
`else
    modport master (
        output MEM_R_EN, MEM_W_EN, WB_EN_in,
        output Dest_in, ALU_Res, Val_Rm,
        input  freeze, WB_EN, WB_Dest, WB_Res
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, WB_EN_in,
        input  Dest_in, ALU_Res, Val_Rm,
        output freeze, WB_EN, WB_Dest, WB_Res
    );
`endif

endinterface

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory with range check.
// Combinational read, posedge write, cleared by reset.
module mem_wb_stage_data_memory
    import mem_wb_stage_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_BASE = DEF_ADDR_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              in_range
);

    localparam int IDX_W =
        (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [WORD_W-1:0] BASE =
        WORD_W'(ADDR_BASE);
    localparam logic [WORD_W-1:0] DEPTH =
        WORD_W'(MEM_WORDS);

    logic [WORD_W-1:0] mem [MEM_WORDS];
    logic [WORD_W-1:0] off;
    logic [WORD_W-1:0] idx;

    // Addresses below the base wrap to huge offsets and fail the check
    assign off      = addr - BASE;
    assign idx      = off >> 2;
    assign in_range = idx < DEPTH;
    assign rdata    = in_range ? mem[idx[IDX_W-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && in_range) begin
            mem[idx[IDX_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with wait-state FSM and MEM/WB register.
// MEM_ALIGN_CHECK_EN enables the sticky misalign flag.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int MEM_WORDS   = 64,
    parameter int ADDR_BASE   = DEF_ADDR_BASE,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              access;
    logic              done;
    logic              stall;
    logic              ld;
    logic              aligned;
    logic              we;
    logic              in_range;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] ldata;
    mem_wb_t           wb;

    assign access = bus.MEM_R_EN | bus.MEM_W_EN;
    assign ld     = bus.MEM_R_EN & ~bus.MEM_W_EN;

`ifdef MEM_ALIGN_CHECK_EN
    assign aligned = (bus.ALU_Res[1:0] == 2'b00);
`else
    assign aligned = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        stall     = 1'b0;
        if (WAIT_CYCLES == 0) begin
            done = access;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                        stall     = 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                        stall   = 1'b1;
                    end else begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Reset must drop the stall request without waiting for an edge
    assign bus.freeze = stall & ~rst;

    assign we    = done & bus.MEM_W_EN & aligned;
    assign ldata = aligned ? rdata : '0;

    mem_wb_stage_data_memory #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_BASE (ADDR_BASE)
    ) u_dmem (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr     (bus.ALU_Res),
        .wdata    (bus.Val_Rm),
        .rdata    (rdata),
        .in_range (in_range)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wb    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall) begin
                wb <= '0;
            end else begin
                wb <= '{
                    wb_en: bus.WB_EN_in,
                    dest:  bus.Dest_in,
                    load:  ld,
                    alu:   bus.ALU_Res,
                    rdata: ldata
                };
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.misalign <= 1'b0;
        end else if (done && !aligned) begin
            bus.misalign <= 1'b1;
        end
    end
`endif

    assign bus.WB_EN   = wb.wb_en;
    assign bus.WB_Dest = wb.dest;
    assign bus.WB_Res  = wb.load ? wb.rdata : wb.alu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances
// against a transaction-level memory model; MEM_ALIGN_CHECK_EN aware.
module tb_mem_wb_stage;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] mdl [2][64];
    bit          mis [2];

    mem_wb_stage_if b1 ();
    mem_wb_stage_if b0 ();

    mem_wb_stage #(.WAIT_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    mem_wb_stage #(.WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] o,
                       logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, o, e);
        end
    endtask

    // which: 0 freeze, 1 WB_EN, 2 WB_Dest, 3 WB_Res, 4 misalign
    function automatic logic [31:0] obs(int d, int which);
        logic [31:0] v;
        v = '0;
        if (d == 1) begin
            case (which)
                0: v = 32'(b1.freeze);
                1: v = 32'(b1.WB_EN);
                2: v = 32'(b1.WB_Dest);
                3: v = b1.WB_Res;
`ifdef MEM_ALIGN_CHECK_EN
                4: v = 32'(b1.misalign);
`endif
                default: v = '0;
            endcase
        end else begin
            case (which)
                0: v = 32'(b0.freeze);
                1: v = 32'(b0.WB_EN);
                2: v = 32'(b0.WB_Dest);
                3: v = b0.WB_Res;
`ifdef MEM_ALIGN_CHECK_EN
                4: v = 32'(b0.misalign);
`endif
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic drive(int d, logic r, logic w, logic wen,
                         logic [3:0] dst, logic [31:0] alu,
                         logic [31:0] val);
        if (d == 1) begin
            b1.MEM_R_EN = r;   b1.MEM_W_EN = w;
            b1.WB_EN_in = wen; b1.Dest_in  = dst;
            b1.ALU_Res  = alu; b1.Val_Rm   = val;
        end else begin
            b0.MEM_R_EN = r;   b0.MEM_W_EN = w;
            b0.WB_EN_in = wen; b0.Dest_in  = dst;
            b0.ALU_Res  = alu; b0.Val_Rm   = val;
        end
    endtask

    task automatic idle_all();
        drive(1, 0, 0, 0, 4'd0, 32'd0, 32'd0);
        drive(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            mis[d] = 0;
            for (int i = 0; i < 64; i++) mdl[d][i] = '0;
        end
    endtask

    // Entered and left on a negedge with rst low
    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(int d);
        chk("rst_freeze", obs(d, 0), 32'd0);
        chk("rst_wb_en",  obs(d, 1), 32'd0);
        chk("rst_dest",   obs(d, 2), 32'd0);
        chk("rst_res",    obs(d, 3), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_misalign", obs(d, 4), 32'd0);
`endif
    endtask

    // One instruction through the stage, checked against the model
    task automatic op(int d, logic r, logic w, logic wen,
                      logic [3:0] dst, logic [31:0] alu,
                      logic [31:0] val);
        int          wt;
        int          lat;
        bit          memop;
        bit          ok;
        logic [31:0] idx;
        logic [31:0] exp_res;
        wt    = (d == 1) ? 1 : 0;
        memop = r | w;
        lat   = memop ? wt + 1 : 1;
        idx   = (alu - 32'd1024) >> 2;
        ok    = (idx < 32'd64);
`ifdef MEM_ALIGN_CHECK_EN
        if (alu[1:0] != 2'b00) ok = 0;
        if (memop && alu[1:0] != 2'b00) mis[d] = 1;
`endif
        if (w && ok) mdl[d][idx[5:0]] = val;
        if (r && !w) exp_res = ok ? mdl[d][idx[5:0]] : 32'd0;
        else         exp_res = alu;
        drive(d, r, w, wen, dst, alu, val);
        for (int i = 0; i < lat; i++) begin
            #1;
            chk("freeze", obs(d, 0),
                32'((memop && i < wt) ? 1 : 0));
            if (i > 0) chk("bubble", obs(d, 1), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("wb_en",   obs(d, 1), 32'(wen));
        chk("wb_dest", obs(d, 2), 32'(dst));
        chk("wb_res",  obs(d, 3), exp_res);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign", obs(d, 4), 32'(mis[d]));
`endif
    endtask

    task automatic rand_op(int d);
        int          k;
        logic [31:0] a;
        k = $urandom_range(0, 3);
        a = 32'd1024 + 32'(4 * $urandom_range(0, 71));
        if ($urandom_range(0, 7) == 0)
            a = a + 32'($urandom_range(1, 3));
        case (k)
            0: op(d, 0, 0, 1'($urandom), 4'($urandom),
                  $urandom, $urandom);
            1: op(d, 1, 0, 1'($urandom), 4'($urandom),
                  a, $urandom);
            2: op(d, 0, 1, 1'($urandom), 4'($urandom),
                  a, $urandom);
            default: op(d, 1, 1, 1'($urandom), 4'($urandom),
                        a, $urandom);
        endcase
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_all();
        clear_model();
        #1;
        chk_reset_state(1);
        chk_reset_state(0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        op(1, 0, 0, 1, 4'd3, 32'h55, 32'd0);
        op(1, 0, 1, 0, 4'd0, 32'd1028, 32'hDEADBEEF);
        op(1, 1, 0, 1, 4'd5, 32'd1028, 32'd0);
        op(1, 0, 1, 0, 4'd0, 32'd1024, 32'h12345678);
        op(1, 1, 0, 1, 4'd1, 32'd1024 + 32'd256, 32'd0);
        op(1, 1, 0, 1, 4'd2, 32'd1024, 32'd0);
        op(1, 1, 1, 1, 4'd9, 32'd1036, 32'hA5A5A5A5);
        op(1, 1, 0, 1, 4'd4, 32'd1036, 32'd0);
        op(1, 1, 0, 1, 4'd6, 32'd1020, 32'd0);

        drive(1, 0, 1, 0, 4'd0, 32'd1032, 32'hCAFEF00D);
        #1;
        chk("pre_rst_freeze", obs(1, 0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("busy_rst_freeze", obs(1, 0), 32'd0);
        chk("busy_rst_wb_en",  obs(1, 1), 32'd0);
        idle_all();
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        op(1, 1, 0, 1, 4'd7, 32'd1032, 32'd0);

        drive(1, 1, 0, 1, 4'd2, 32'd1040, 32'd0);
        #1;
        chk("idle_freeze", obs(1, 0), 32'd1);
        rst = 1'b1;
        #1;
        chk("idle_rst_freeze", obs(1, 0), 32'd0);
        idle_all();
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state(1);

`ifdef MEM_ALIGN_CHECK_EN
        op(1, 0, 1, 0, 4'd0, 32'd1026, 32'h11112222);
        op(1, 0, 0, 1, 4'd8, 32'h77, 32'd0);
        op(1, 1, 0, 1, 4'd8, 32'd1024, 32'd0);
        do_reset();
        chk_reset_state(1);
`endif

        for (int n = 0; n < 40; n++) rand_op(1);

        op(0, 0, 1, 0, 4'd0, 32'd1028, 32'h0BADF00D);
        op(0, 1, 0, 1, 4'd5, 32'd1028, 32'd0);
        op(0, 0, 1, 1, 4'd1, 32'd1100, 32'h13579BDF);
        op(0, 1, 0, 1, 4'd2, 32'd1100, 32'd0);
        op(0, 1, 0, 1, 4'd3, 32'd1024 + 32'd256, 32'd0);
        for (int n = 0; n < 40; n++) rand_op(0);

        idle_all();
        @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
